// File: rtl/cloud_ctrl_pkg.sv
// Shared definitions for the cloud controller: geometry, descriptor layout, state encodings.
package cloud_ctrl_pkg;

  localparam int unsigned SCREEN_W     = 640;
  localparam int unsigned CLOUD_W      = 92;
  localparam int unsigned NUM_SLOTS    = 2;
  localparam int unsigned SLOT_IDX_W   = 1;
  localparam int unsigned X_W          = 10;
  localparam int unsigned Y_W          = 5;
  localparam int unsigned DESC_W       = 1 + Y_W + X_W;
  localparam int unsigned STATE_W      = 2;
  localparam int unsigned GAP_W        = 8;
  localparam int unsigned LFSR_W       = 16;
  localparam int unsigned GAP_RAND_LSB = 6;
  localparam int unsigned GAP_RAND_W   = 7;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FROZEN = 2'b10
  } state_e;

  // Descriptor: [15] valid, [14:10] y offset, [9:0] right-edge x
  typedef struct packed {
    logic           valid;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } cloud_t;

  // Build the descriptor of a freshly spawned cloud
  function automatic cloud_t spawn_desc(input logic [Y_W-1:0] y, input logic [X_W-1:0] x);
    cloud_t d;
    d.valid = 1'b1;
    d.y     = y;
    d.x     = x;
    return d;
  endfunction

endpackage

// File: rtl/cloud_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the cloud randomness source.
module lfsr16
  import cloud_ctrl_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] q
);

  // Shift right every clock; fold the output bit back through the tap mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else begin
      q <= {1'b0, q[LFSR_W-1:1]} ^ (q[0] ? LFSR_MASK : '0);
    end
  end

endmodule

// File: rtl/cloud_ctrl.sv
// Cloud background controller: two scrolling cloud slots with random spawn height and spacing.
module cloud_ctrl
  import cloud_ctrl_pkg::*;
#(
  parameter int unsigned       MOVE_DIV = 4,
  parameter int unsigned       MIN_GAP  = 90,
  parameter logic [X_W-1:0]    SPAWN_X  = X_W'(SCREEN_W + CLOUD_W),
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  output logic [DESC_W-1:0]  cloud0,
  output logic [DESC_W-1:0]  cloud1,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned       STEP_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MOVE_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_BASE  = GAP_W'(MIN_GAP);

  state_e                  state_q;
  state_e                  state_d;
  logic [STEP_W-1:0]       step_q;
  logic [STEP_W-1:0]       step_d;
  logic [GAP_W-1:0]        gap_q;
  logic [GAP_W-1:0]        gap_d;
  cloud_t                  slot_q [NUM_SLOTS];
  cloud_t                  slot_d [NUM_SLOTS];
  logic [LFSR_W-1:0]       lfsr;
  logic                    run_tick;
  logic                    step_wrap;
  logic                    spawn_ok;
  logic [SLOT_IDX_W-1:0]   spawn_idx;
  logic                    idle_start;
  logic                    lfsr_unused;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  // Only some LFSR bits feed the datapath
  assign lfsr_unused = ^{lfsr[LFSR_W-1:GAP_RAND_LSB+GAP_RAND_W], lfsr[GAP_RAND_LSB-1:Y_W]};

  // Frame ticks act on the state held before any same-edge control transition
  assign run_tick   = frame_tick && (state_q == ST_RUN);
  assign step_wrap  = (step_q == STEP_LAST);
  assign idle_start = start && !stop && !clear && (state_q == ST_IDLE);

  // Next-state logic: clear beats stop, stop beats start
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (stop) begin
      if (state_q == ST_RUN) begin
        state_d = ST_FROZEN;
      end
    end else if (start) begin
      if (state_q == ST_IDLE || state_q == ST_FROZEN) begin
        state_d = ST_RUN;
      end
    end
  end

  // Lowest-index slot that is free before this tick
  always_comb begin
    spawn_ok  = 1'b0;
    spawn_idx = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!slot_q[i].valid) begin
        spawn_ok  = 1'b1;
        spawn_idx = SLOT_IDX_W'(i);
      end
    end
  end

  // Movement, retirement, spawn and gap pacing; clear wipes everything
  always_comb begin
    slot_d = slot_q;
    step_d = step_q;
    gap_d  = gap_q;

    if (run_tick) begin
      step_d = step_wrap ? '0 : step_q + STEP_W'(1);

      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        if (step_wrap && slot_q[i].valid) begin
          if (slot_q[i].x == '0) begin
            slot_d[i] = '0;
          end else begin
            slot_d[i].x = slot_q[i].x - X_W'(1);
          end
        end
      end

      gap_d = (gap_q != '0) ? gap_q - GAP_W'(1) : '0;

      // A slot spawned this tick overrides any movement computed above (it was invalid anyway)
      if (gap_q == '0 && spawn_ok) begin
        slot_d[spawn_idx] = spawn_desc(lfsr[Y_W-1:0], SPAWN_X);
        gap_d = GAP_BASE + GAP_W'(lfsr[GAP_RAND_LSB +: GAP_RAND_W]);
      end
    end

    if (clear) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        slot_d[i] = '0;
      end
      step_d = '0;
      gap_d  = '0;
    end else if (idle_start) begin
      step_d = '0;
      gap_d  = '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      gap_q  <= '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      step_q <= step_d;
      gap_q  <= gap_d;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign cloud0 = slot_q[0];
  assign cloud1 = slot_q[1];
  assign state  = state_q;

endmodule

// File: tb/tb_cloud_ctrl.sv
// Directed bench for cloud_ctrl: vector table on a default instance, run-down/retire sequence on a MOVE_DIV=1 instance.
module tb_cloud_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic a_tick = 1'b0, a_start = 1'b0, a_stop = 1'b0, a_clear = 1'b0;
  logic b_tick = 1'b0, b_start = 1'b0, b_stop = 1'b0, b_clear = 1'b0;
  logic [15:0] a_c0, a_c1, b_c0, b_c1;
  logic [1:0]  a_st, b_st;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cloud_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(a_tick), .start(a_start), .stop(a_stop),
    .clear(a_clear), .cloud0(a_c0), .cloud1(a_c1), .state(a_st)
  );

  cloud_ctrl #(.MOVE_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(b_tick), .start(b_start), .stop(b_stop),
    .clear(b_clear), .cloud0(b_c0), .cloud1(b_c1), .state(b_st)
  );

  // Reference LFSR: x^16+x^14+x^13+x^11+1, shift right, toggle taps when bit 0 falls out
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) begin
      r[15] = ~r[15];
      r[13] = ~r[13];
      r[12] = ~r[12];
      r[10] = ~r[10];
    end
    return r;
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock on instance A; y returns the LFSR low bits seen at the active edge
  task automatic cyc_a(input logic cl, input logic sp, input logic st, input logic tk,
                       output logic [4:0] y);
    @(negedge clk);
    a_clear = cl; a_stop = sp; a_start = st; a_tick = tk;
    y = m_lfsr[4:0];
    @(posedge clk);
    #1;
    a_clear = 1'b0; a_stop = 1'b0; a_start = 1'b0; a_tick = 1'b0;
  endtask

  task automatic cyc_b(input logic st, input logic tk, output logic [4:0] y);
    @(negedge clk);
    b_start = st; b_tick = tk;
    y = m_lfsr[4:0];
    @(posedge clk);
    #1;
    b_start = 1'b0; b_tick = 1'b0;
  endtask

  typedef struct {
    logic       clear, stop, start, tick;
    logic [1:0] st;
    logic       v0;
    logic [9:0] x0;
    logic       spawn;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic cl, input logic sp, input logic st, input logic tk,
                              input logic [1:0] est, input logic v0, input logic [9:0] x0,
                              input logic spawn);
    vec_t v;
    v.clear = cl; v.stop = sp; v.start = st; v.tick = tk;
    v.st = est; v.v0 = v0; v.x0 = x0; v.spawn = spawn;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [4:0]  y;
    logic [4:0]  last_y;
    logic [15:0] exp0;
    int          cnt;

    last_y = '0;

    // Reset values while rst_n held low
    @(negedge clk);
    check16("reset_cloud0", a_c0, 16'h0000);
    check16("reset_cloud1", a_c1, 16'h0000);
    check16("reset_state", 16'(a_st), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // clear, stop, start, tick -> state, valid0, x0, spawn-expected
    add(0,0,0,0, 2'b00, 0,   0, 0);
    add(0,0,0,1, 2'b00, 0,   0, 0);   // tick in IDLE ignored
    add(0,0,1,0, 2'b01, 0,   0, 0);   // start
    add(0,0,0,1, 2'b01, 1, 732, 1);   // first tick spawns (gap loaded 0)
    add(0,0,0,1, 2'b01, 1, 732, 0);   // step 1->2
    add(0,0,0,1, 2'b01, 1, 732, 0);   // 2->3
    add(0,0,0,1, 2'b01, 1, 731, 0);   // 3->0 move
    add(0,0,0,1, 2'b01, 1, 731, 0);
    add(0,0,0,1, 2'b01, 1, 731, 0);
    add(0,0,0,1, 2'b01, 1, 731, 0);
    add(0,0,0,1, 2'b01, 1, 730, 0);   // second move
    add(0,0,0,1, 2'b01, 1, 730, 0);   // 8 ticks after spawn -> 730
    add(0,1,1,1, 2'b10, 1, 730, 0);   // stop wins; tick still handled as RUN (step 1->2)
    for (int i = 0; i < 20; i++) add(0,0,0,1, 2'b10, 1, 730, 0);
    add(0,0,1,0, 2'b01, 1, 730, 0);   // resume
    add(0,0,0,1, 2'b01, 1, 730, 0);   // 2->3
    add(0,0,0,1, 2'b01, 1, 729, 0);   // 3->0 move
    add(0,0,0,0, 2'b01, 1, 729, 0);
    add(1,0,0,1, 2'b00, 0,   0, 0);   // clear with tick
    add(0,0,0,1, 2'b00, 0,   0, 0);
    add(0,0,1,1, 2'b01, 0,   0, 0);   // start+tick: tick uses IDLE, no spawn
    add(0,0,0,1, 2'b01, 1, 732, 1);   // spawn
    add(0,1,0,0, 2'b10, 1, 732, 0);   // stop
    add(0,0,1,1, 2'b01, 1, 732, 0);   // start+tick: tick uses FROZEN, ignored
    add(0,0,0,1, 2'b01, 1, 732, 0);   // 1->2
    add(0,0,0,1, 2'b01, 1, 732, 0);   // 2->3
    add(0,0,0,1, 2'b01, 1, 731, 0);   // 3->0 move
    add(0,1,0,0, 2'b10, 1, 731, 0);
    add(1,0,1,0, 2'b00, 0,   0, 0);   // clear beats start from FROZEN

    foreach (vecs[i]) begin
      cyc_a(vecs[i].clear, vecs[i].stop, vecs[i].start, vecs[i].tick, y);
      if (vecs[i].spawn) last_y = y;
      exp0 = vecs[i].v0 ? {1'b1, last_y, vecs[i].x0} : 16'h0000;
      check16($sformatf("vec%0d_state", i), 16'(a_st), 16'(vecs[i].st));
      check16($sformatf("vec%0d_cloud0", i), a_c0, exp0);
      check16($sformatf("vec%0d_cloud1", i), a_c1, 16'h0000);
    end

    // Asynchronous reset mid-RUN
    cyc_a(0,0,1,0, y);
    cyc_a(0,0,0,1, y);
    check16("pre_reset_cloud0", a_c0, {1'b1, y, 10'd732});
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check16("async_reset_cloud0", a_c0, 16'h0000);
    check16("async_reset_cloud1", a_c1, 16'h0000);
    check16("async_reset_state", 16'(a_st), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc_a(0,0,0,1, y);
    check16("post_reset_no_spawn", a_c0, 16'h0000);
    check16("post_reset_state", 16'(a_st), 16'h0000);

    // Instance B (MOVE_DIV=1): run slot 0 down to x=0, retire, then refill
    cyc_b(1'b1, 1'b0, y);
    check16("b_start_state", 16'(b_st), 16'h0001);
    cyc_b(1'b0, 1'b1, y);
    last_y = y;
    check16("b_spawn_cloud0", b_c0, {1'b1, last_y, 10'd732});
    cnt = 0;
    while (b_c0[9:0] != 10'd0 && cnt < 800) begin
      cyc_b(1'b0, 1'b1, y);
      cnt++;
    end
    check_int("b_rundown_ticks", cnt, 732);
    check16("b_at_zero_cloud0", b_c0, {1'b1, last_y, 10'd0});
    check16("b_both_valid", 16'(b_c1[15]), 16'h0001);
    cyc_b(1'b0, 1'b1, y);
    check16("b_retired_cloud0", b_c0, 16'h0000);
    check16("b_slot1_kept", 16'(b_c1[15]), 16'h0001);
    cyc_b(1'b0, 1'b1, y);
    check16("b_refill_cloud0", b_c0, {1'b1, y, 10'd732});
    check16("b_refill_state", 16'(b_st), 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
